// File: rtl/hb_interp_x2_if.sv
// Strobe and sample bundle between the pulse shaper side (master) and the
// halfband 2x interpolator (slave).
interface hb_interp_x2_if #(
    parameter int WIDTH = 18
);
    logic             sam_clk_en;
    logic             sys_clk2_en;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y;
    logic             y_phase;
    logic             phase_err;

    modport master (
        output sam_clk_en, sys_clk2_en, x_in,
        input  y, y_phase, phase_err
    );

    modport slave (
        input  sam_clk_en, sys_clk2_en, x_in,
        output y, y_phase, phase_err
    );
endinterface

// File: rtl/hb_interp_x2.sv
// Halfband 2x interpolator: branch A = 8-tap symmetric subfilter, branch B = centre tap.
// Define HB_ROUND_EN to round products (half up) before slicing; default truncates.
module hb_interp_x2 #(
    parameter int WIDTH   = 18,
    parameter int NPAIR   = 4,
    parameter int CTR_IDX = 3
) (
    input logic           sys_clk,
    input logic           reset,
    hb_interp_x2_if.slave bus
);
    localparam int NTAP = 2 * NPAIR;
    localparam int NSUM = NPAIR / 2;
    localparam int PW   = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0] samp_t;
    typedef logic signed [WIDTH:0]   sum_t;
    typedef logic signed [WIDTH+1:0] acc_t;
    typedef logic signed [WIDTH+2:0] wide_t;
    typedef logic signed [PW-1:0]    prod_t;

    // SLOT_NONE lets the first A strobe after reset pass without an error.
    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_A,
        SLOT_B
    } slot_t;

    localparam wide_t WIDE_HI = wide_t'((1 << (WIDTH - 1)) - 1);
    localparam wide_t WIDE_LO = wide_t'(-(1 << (WIDTH - 1)));
`ifdef HB_ROUND_EN
    localparam prod_t RND = prod_t'(1) <<< (WIDTH - 2);
`endif

    function automatic samp_t coef(input int unsigned k);
        case (k)
            0:       coef = samp_t'(-348);
            1:       coef = samp_t'(3274);
            2:       coef = samp_t'(-15925);
            3:       coef = samp_t'(78535);
            default: coef = '0;
        endcase
    endfunction

    // Applies the interpolation gain of 2 and clamps to the output range.
    function automatic samp_t sat_x2(input acc_t v);
        wide_t w;
        w = wide_t'(v) <<< 1;
        if (w > WIDE_HI)
            sat_x2 = samp_t'(WIDE_HI);
        else if (w < WIDE_LO)
            sat_x2 = samp_t'(WIDE_LO);
        else
            sat_x2 = samp_t'(w);
    endfunction

    samp_t xd     [NTAP];
    samp_t pp     [NPAIR];
    prod_t mm     [NPAIR];
    samp_t mslice [NPAIR];
    sum_t  ss     [NSUM];
    acc_t  acc_a;
    acc_t  acc_next;
    samp_t c1;
    samp_t c2;
    samp_t c3;
    samp_t x_half;

    samp_t y_q;
    logic  y_phase_q;
    logic  phase_err_q;
    slot_t slot_q;
    slot_t slot_d;
    logic  err_set;

    assign x_half = samp_t'($signed(bus.x_in) >>> 1);

    always_comb begin
        for (int unsigned k = 0; k < NPAIR; k++) begin
            mm[k] = prod_t'(coef(k)) * prod_t'(pp[k]);
`ifdef HB_ROUND_EN
            mm[k] = mm[k] + RND;
`endif
            mslice[k] = samp_t'(mm[k] >>> (WIDTH - 1));
        end
        acc_next = '0;
        for (int unsigned j = 0; j < NSUM; j++)
            acc_next = acc_next + acc_t'(ss[j]);
    end

    // Datapath: delay line, pre-add, product pair sums and accumulator all step on sam_clk_en.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NTAP; i++)
                xd[i] <= '0;
            for (int unsigned k = 0; k < NPAIR; k++)
                pp[k] <= '0;
            for (int unsigned j = 0; j < NSUM; j++)
                ss[j] <= '0;
            acc_a <= '0;
            c1    <= '0;
            c2    <= '0;
            c3    <= '0;
        end else if (bus.sam_clk_en) begin
            xd[0] <= x_half;
            for (int unsigned i = 1; i < NTAP; i++)
                xd[i] <= xd[i-1];
            for (int unsigned k = 0; k < NPAIR; k++)
                pp[k] <= xd[k] + xd[NTAP-1-k];
            for (int unsigned j = 0; j < NSUM; j++)
                ss[j] <= sum_t'(mslice[2*j]) + sum_t'(mslice[2*j+1]);
            acc_a <= acc_next;
            c1    <= xd[CTR_IDX];
            c2    <= c1;
            c3    <= c2;
        end
    end

    always_comb begin
        slot_d  = slot_q;
        err_set = 1'b0;
        if (bus.sam_clk_en && !bus.sys_clk2_en)
            err_set = 1'b1;
        if (bus.sys_clk2_en) begin
            if (bus.sam_clk_en) begin
                if (slot_q == SLOT_A)
                    err_set = 1'b1;
                slot_d = SLOT_A;
            end else begin
                slot_d = SLOT_B;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            slot_q      <= SLOT_NONE;
            y_q         <= '0;
            y_phase_q   <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            if (err_set)
                phase_err_q <= 1'b1;
            if (bus.sys_clk2_en) begin
                if (bus.sam_clk_en) begin
                    y_q       <= sat_x2(acc_a);
                    y_phase_q <= 1'b0;
                end else begin
                    y_q       <= sat_x2(acc_t'(c3));
                    y_phase_q <= 1'b1;
                end
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.y_phase   = y_phase_q;
    assign bus.phase_err = phase_err_q;
endmodule
